video_nn_scaler: RTL and testbench

Parametrised nearest-neighbour video downscaler for the RGB capture path, placed between the video input timing stage and the frame-buffer write packer. It decimates an incoming frame of vin_xres × vin_yres to vout_xres × vout_yres, with resolutions programmable at run time. Scale factors are computed once per frame by an internal sequential divider, so the pixel path carries no combinational divider. The block also provides bypass, configuration-error and frame-drop handling.

---
 rtl/video_nn_scaler_if.sv | 13 +
 rtl/video_nn_scaler.sv | 186 ++++++++++++++++++
 tb/tb_video_nn_scaler.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_nn_scaler_if.sv
// Video timing and pixel bundle (sync, data enable, pixel) shared by the
// scaler's input and output sides.
interface video_nn_scaler_if #(
  parameter int DATA_W = 24
);
  logic              vs;
  logic              hs;
  logic              de;
  logic [DATA_W-1:0] data;

  modport master (output vs, hs, de, data);
  modport slave  (input  vs, hs, de, data);
endinterface

// File: rtl/video_nn_scaler.sv
// Nearest-neighbour downscaler: per-frame scale factors from a restoring
// divider, then fixed-point accumulators pick which input pixels survive.
module video_nn_scaler #(
  parameter int DATA_W = 24,
  parameter int RES_W  = 12,
  parameter int FRAC_W = 16
) (
  input  logic              pixclk_in,
  input  logic              rst,
  input  logic [RES_W-1:0]  vin_xres,
  input  logic [RES_W-1:0]  vin_yres,
  input  logic [RES_W-1:0]  vout_xres,
  input  logic [RES_W-1:0]  vout_yres,
  input  logic              scale_en,
  video_nn_scaler_if.slave  vid_in,
  video_nn_scaler_if.master vid_out,
  output logic              cfg_busy,
  output logic              cfg_err
);

  localparam int ACC_W = RES_W + FRAC_W;
  localparam int CNT_W = $clog2(ACC_W);
  localparam logic [ACC_W-1:0] SF_ONE   = {{(RES_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [RES_W-1:0] RES_ONE  = RES_W'(1);

  typedef enum logic {ST_IDLE, ST_DIV} div_state_t;

  div_state_t        r_state;
  logic              r_vs_prev;
  logic [RES_W-1:0]  r_xi, r_yi, r_xo, r_yo;
  logic [CNT_W-1:0]  r_cnt;
  logic [RES_W-1:0]  r_rem_x, r_rem_y;
  logic [ACC_W-2:0]  r_q_x, r_q_y;
  logic [ACC_W-1:0]  r_sf_x, r_sf_y;
  logic              r_err, r_drop;

  logic              r_de_prev;
  logic [RES_W-1:0]  r_x, r_y;
  logic [ACC_W-1:0]  r_acc_x, r_acc_y;
  logic              r_vs_o, r_hs_o, r_de_o;
  logic [DATA_W-1:0] r_data_o;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    // NOTE: blocking assignment is right here: s is a function-local temporary, not state.
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  logic w_vs_rise, w_cfg_bad;
  assign w_vs_rise = vid_in.vs & ~r_vs_prev;
  assign w_cfg_bad = (vin_xres == '0) | (vin_yres == '0) | (vout_xres == '0) |
                     (vout_yres == '0) | (vout_xres > vin_xres) | (vout_yres > vin_yres);

  // Dividend is vin << FRAC_W, consumed MSB first as r_cnt counts down.
  logic [ACC_W-1:0] w_dvd_x, w_dvd_y;
  logic [RES_W:0]   w_trial_x, w_trial_y;
  logic [RES_W-1:0] w_sub_x, w_sub_y;
  logic             w_ge_x, w_ge_y;
  logic [ACC_W-1:0] w_q_x, w_q_y;
  assign w_dvd_x   = {r_xi, {FRAC_W{1'b0}}};
  assign w_dvd_y   = {r_yi, {FRAC_W{1'b0}}};
  assign w_trial_x = {r_rem_x, w_dvd_x[r_cnt]};
  assign w_trial_y = {r_rem_y, w_dvd_y[r_cnt]};
  assign w_ge_x    = w_trial_x >= {1'b0, r_xo};
  assign w_ge_y    = w_trial_y >= {1'b0, r_yo};
  assign w_sub_x   = RES_W'(w_trial_x - {1'b0, r_xo});
  assign w_sub_y   = RES_W'(w_trial_y - {1'b0, r_yo});
  assign w_q_x     = {r_q_x, w_ge_x};
  assign w_q_y     = {r_q_y, w_ge_y};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vs_prev <= 1'b0;
      r_xi      <= '0;
      r_yi      <= '0;
      r_xo      <= '0;
      r_yo      <= '0;
      r_cnt     <= '0;
      r_rem_x   <= '0;
      r_rem_y   <= '0;
      r_q_x     <= '0;
      r_q_y     <= '0;
      r_sf_x    <= SF_ONE;
      r_sf_y    <= SF_ONE;
      r_err     <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_vs_prev <= vid_in.vs;
      if (w_vs_rise) begin
        r_xi    <= vin_xres;
        r_yi    <= vin_yres;
        r_xo    <= vout_xres;
        r_yo    <= vout_yres;
        r_drop  <= 1'b0;
        r_cnt   <= CNT_LAST;
        r_rem_x <= '0;
        r_rem_y <= '0;
        r_q_x   <= '0;
        r_q_y   <= '0;
        if (w_cfg_bad || !scale_en) begin
          r_err   <= w_cfg_bad;
          r_sf_x  <= SF_ONE;
          r_sf_y  <= SF_ONE;
          r_state <= ST_IDLE;
        end else begin
          r_err   <= 1'b0;
          r_state <= ST_DIV;
        end
      end else if (r_state == ST_DIV) begin
        r_rem_x <= w_ge_x ? w_sub_x : w_trial_x[RES_W-1:0];
        r_rem_y <= w_ge_y ? w_sub_y : w_trial_y[RES_W-1:0];
        r_q_x   <= w_q_x[ACC_W-2:0];
        r_q_y   <= w_q_y[ACC_W-2:0];
        if (r_cnt == '0) begin
          r_sf_x  <= w_q_x + SF_ONE[ACC_W-1:0] - SF_ONE + ACC_W'(1);
          r_sf_y  <= w_q_y + ACC_W'(1);
          r_state <= ST_IDLE;
        end else begin
          r_cnt <= r_cnt - CNT_ONE;
        end
        // Pixels arriving before the factors are ready would be mis-scaled.
        if (vid_in.de) begin
          r_drop <= 1'b1;
          r_err  <= 1'b1;
        end
      end
    end
  end

  logic w_sel, w_drop, w_emit, w_line_end;
  assign w_sel  = vid_in.de & (r_x == r_acc_x[ACC_W-1:FRAC_W]) &
                  (r_y == r_acc_y[ACC_W-1:FRAC_W]) & ~(&r_acc_x) & ~(&r_acc_y);
  assign w_drop = r_drop | (vid_in.de & (r_state == ST_DIV));
  assign w_emit = w_sel & ~w_drop;
  // Second term recovers from lines shorter than the programmed width.
  assign w_line_end = (vid_in.de & (r_x == (r_xi - RES_ONE))) |
                      (~vid_in.de & r_de_prev & (r_x != '0));

  always_ff @(posedge pixclk_in) begin
    if (rst) begin
      r_de_prev <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_acc_x   <= '0;
      r_acc_y   <= '0;
      r_vs_o    <= 1'b0;
      r_hs_o    <= 1'b0;
      r_de_o    <= 1'b0;
      r_data_o  <= '0;
    end else begin
      r_de_prev <= vid_in.de;
      if (vid_in.vs) begin
        r_x     <= '0;
        r_y     <= '0;
        r_acc_x <= '0;
        r_acc_y <= '0;
      end else if (w_line_end) begin
        r_x     <= '0;
        r_acc_x <= '0;
        r_y     <= r_y + RES_ONE;
        if (r_y == r_acc_y[ACC_W-1:FRAC_W]) r_acc_y <= sat_add(r_acc_y, r_sf_y);
      end else begin
        if (vid_in.de) r_x <= r_x + RES_ONE;
        if (w_sel) r_acc_x <= sat_add(r_acc_x, r_sf_x);
      end
      r_vs_o   <= vid_in.vs;
      r_hs_o   <= vid_in.hs;
      r_de_o   <= w_emit;
      r_data_o <= w_emit ? vid_in.data : '0;
    end
  end

  assign vid_out.vs   = r_vs_o;
  assign vid_out.hs   = r_hs_o;
  assign vid_out.de   = r_de_o;
  assign vid_out.data = r_data_o;
  assign cfg_busy     = (r_state == ST_DIV);
  assign cfg_err      = r_err;

endmodule

// File: tb/tb_video_nn_scaler.sv
// Randomised bench for video_nn_scaler: a set-based selection model predicts
// every surviving pixel and its output cycle; a monitor records what emerges.
module tb_video_nn_scaler;

  localparam int DATA_W = 24;
  localparam int RES_W  = 12;
  localparam int FRAC_W = 16;
  localparam int ACC_W  = RES_W + FRAC_W;
  localparam longint SF_ONE = longint'(1) << FRAC_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [RES_W-1:0]  vin_xres = '0, vin_yres = '0, vout_xres = '0, vout_yres = '0;
  logic              scale_en = 1'b0;
  logic              cfg_busy, cfg_err;

  video_nn_scaler_if #(.DATA_W(DATA_W)) vid_in ();
  video_nn_scaler_if #(.DATA_W(DATA_W)) vid_out ();

  video_nn_scaler #(.DATA_W(DATA_W), .RES_W(RES_W), .FRAC_W(FRAC_W)) dut (
    .pixclk_in (clk),
    .rst       (rst),
    .vin_xres  (vin_xres),
    .vin_yres  (vin_yres),
    .vout_xres (vout_xres),
    .vout_yres (vout_yres),
    .scale_en  (scale_en),
    .vid_in    (vid_in),
    .vid_out   (vid_out),
    .cfg_busy  (cfg_busy),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } pix_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     cyc      = 0;
  pix_t   exp_q[$];
  pix_t   obs_q[$];
  int     idle_bad = 0;
  int     sync_bad = 0;
  int     busy_cycles = 0;
  logic   p_vs = 1'b0, p_hs = 1'b0, p_rst = 1'b1;
  bit     sel_x[4096];
  bit     sel_y[4096];
  longint exp_sfx, exp_sfy;
  bit     exp_err;
  int     exp_busy;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    p_vs  <= vid_in.vs;
    p_hs  <= vid_in.hs;
    p_rst <= rst;
  end

  always @(negedge clk) begin : monitor
    pix_t p;
    if (vid_out.de === 1'b1) begin
      p.cyc  = cyc;
      p.data = vid_out.data;
      obs_q.push_back(p);
    end else if (!p_rst && vid_out.data !== '0) begin
      idle_bad++;
    end
    if (!p_rst && (vid_out.vs !== p_vs || vid_out.hs !== p_hs)) sync_bad++;
    if (cfg_busy === 1'b1) busy_cycles++;
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: output pixel k of a line sits at input x = floor(k * sf); sf from plain division.
  task automatic model_cfg(input int xi, input int yi, input int xo, input int yo, input bit en);
    bit bad;
    bad = (xi == 0) || (yi == 0) || (xo == 0) || (yo == 0) || (xo > xi) || (yo > yi);
    for (int i = 0; i < 4096; i++) begin
      sel_x[i] = bad || !en;
      sel_y[i] = bad || !en;
    end
    exp_err  = bad;
    exp_busy = (!bad && en) ? ACC_W : 0;
    if (bad || !en) begin
      exp_sfx = SF_ONE;
      exp_sfy = SF_ONE;
    end else begin
      exp_sfx = ((longint'(xi) << FRAC_W) / xo) + 1;
      exp_sfy = ((longint'(yi) << FRAC_W) / yo) + 1;
      for (int k = 0; k < xo; k++) sel_x[int'((k * exp_sfx) >> FRAC_W)] = 1'b1;
      for (int k = 0; k < yo; k++) sel_y[int'((k * exp_sfy) >> FRAC_W)] = 1'b1;
    end
    vin_xres  = RES_W'(xi);
    vin_yres  = RES_W'(yi);
    vout_xres = RES_W'(xo);
    vout_yres = RES_W'(yo);
    scale_en  = en;
  endtask

  task automatic drive_vs(input int vs_len, input int bp);
    busy_cycles = 0;
    vid_in.vs = 1'b1;
    step(vs_len);
    vid_in.vs = 1'b0;
    step(bp);
  endtask

  task automatic drive_lines(input int nlines, input int xres, input int short_len,
                             input bit expect_px, input bit ramp);
    pix_t e;
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (short_len > 0 && (l % 2) == 1) ? short_len : xres;
      vid_in.hs = 1'b1;
      step(2);
      vid_in.hs = 1'b0;
      step(2);
      for (int x = 0; x < len; x++) begin
        vid_in.de   = 1'b1;
        vid_in.data = ramp ? DATA_W'({l[11:0], x[11:0]}) : DATA_W'($urandom);
        if (expect_px && sel_x[x] && sel_y[l]) begin
          e.cyc  = cyc + 1;
          e.data = vid_in.data;
          exp_q.push_back(e);
        end
        step(1);
      end
      vid_in.de   = 1'b0;
      vid_in.data = DATA_W'($urandom);
    end
    step(3);
  endtask

  task automatic compare_cfg(input string name, input int want_busy);
    n_checks++;
    if (dut.r_sf_x !== ACC_W'(exp_sfx)) begin
      n_fail++;
      $display("FAIL %s sf_x: got %0h, expected %0h", name, dut.r_sf_x, exp_sfx);
    end
    n_checks++;
    if (dut.r_sf_y !== ACC_W'(exp_sfy)) begin
      n_fail++;
      $display("FAIL %s sf_y: got %0h, expected %0h", name, dut.r_sf_y, exp_sfy);
    end
    n_checks++;
    if (cfg_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s cfg_err: got %b, expected %b", name, cfg_err, exp_err);
    end
    if (want_busy >= 0) begin
      n_checks++;
      if (busy_cycles != want_busy) begin
        n_fail++;
        $display("FAIL %s busy cycles: got %0d, expected %0d", name, busy_cycles, want_busy);
      end
    end
  endtask

  task automatic compare_frame(input string name);
    int bad_idx;
    step(2);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s pixel count: got %0d, expected %0d", name, obs_q.size(), exp_q.size());
    end
    bad_idx = -1;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      if (bad_idx < 0 && (obs_q[i].cyc != exp_q[i].cyc || obs_q[i].data !== exp_q[i].data))
        bad_idx = i;
    n_checks++;
    if (bad_idx >= 0) begin
      n_fail++;
      $display("FAIL %s pixel %0d: got cyc %0d data %0h, expected cyc %0d data %0h", name,
               bad_idx, obs_q[bad_idx].cyc, obs_q[bad_idx].data,
               exp_q[bad_idx].cyc, exp_q[bad_idx].data);
    end
    n_checks++;
    if (idle_bad != 0) begin
      n_fail++;
      $display("FAIL %s idle data_out: got %0d nonzero cycles, expected 0", name, idle_bad);
    end
    n_checks++;
    if (sync_bad != 0) begin
      n_fail++;
      $display("FAIL %s sync delay: got %0d mismatching cycles, expected 0", name, sync_bad);
    end
    obs_q.delete();
    exp_q.delete();
    idle_bad = 0;
    sync_bad = 0;
  endtask

  task automatic test_reset();
    vid_in.vs   = 1'b1;
    vid_in.hs   = 1'b1;
    vid_in.de   = 1'b1;
    vid_in.data = DATA_W'($urandom);
    rst = 1'b1;
    step(3);
    n_checks++;
    if ({vid_out.vs, vid_out.hs, vid_out.de} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset sync: got %b, expected 000", {vid_out.vs, vid_out.hs, vid_out.de});
    end
    n_checks++;
    if (vid_out.data !== '0) begin
      n_fail++;
      $display("FAIL reset data_out: got %0h, expected 0", vid_out.data);
    end
    n_checks++;
    if ({cfg_busy, cfg_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset cfg: got busy/err %b, expected 00", {cfg_busy, cfg_err});
    end
    n_checks++;
    if (dut.r_sf_x !== ACC_W'(SF_ONE) || dut.r_sf_y !== ACC_W'(SF_ONE)) begin
      n_fail++;
      $display("FAIL reset sf: got %0h/%0h, expected %0h", dut.r_sf_x, dut.r_sf_y, SF_ONE);
    end
    vid_in.vs   = 1'b0;
    vid_in.hs   = 1'b0;
    vid_in.de   = 1'b0;
    vid_in.data = '0;
    step(1);
    rst = 1'b0;
    step(2);
    obs_q.delete();
    idle_bad = 0;
    sync_bad = 0;
  endtask

  task automatic test_downscale_2to1();
    model_cfg(64, 16, 32, 8, 1'b1);
    drive_vs(4, 36);
    compare_cfg("2to1", ACC_W);
    drive_lines(16, 64, 0, 1'b1, 1'b1);
    n_checks++;
    if (obs_q.size() != 32 * 8) begin
      n_fail++;
      $display("FAIL 2to1 output pixels: got %0d, expected %0d", obs_q.size(), 32 * 8);
    end
    compare_frame("2to1");
  endtask

  task automatic test_non_integer();
    model_cfg(48, 6, 32, 6, 1'b1);
    drive_vs(4, 36);
    compare_cfg("3to2", ACC_W);
    drive_lines(6, 48, 0, 1'b1, 1'b1);
    compare_frame("3to2");
  endtask

  task automatic test_invalid();
    model_cfg(64, 16, 0, 8, 1'b1);
    drive_vs(4, 36);
    compare_cfg("invalid_xo0", 0);
    drive_lines(16, 64, 0, 1'b1, 1'b0);
    compare_frame("invalid_xo0");
    model_cfg(64, 16, 32, 20, 1'b1);
    drive_vs(4, 36);
    compare_cfg("invalid_yo_big", 0);
    drive_lines(16, 64, 0, 1'b1, 1'b0);
    compare_frame("invalid_yo_big");
  endtask

  task automatic test_passthrough();
    model_cfg(40, 8, 20, 4, 1'b0);
    drive_vs(4, 36);
    compare_cfg("passthrough", 0);
    drive_lines(8, 40, 0, 1'b1, 1'b0);
    compare_frame("passthrough");
  endtask

  task automatic test_frame_drop();
    model_cfg(64, 16, 32, 8, 1'b1);
    drive_vs(4, 10);
    drive_lines(16, 64, 0, 1'b0, 1'b1);
    compare_frame("drop");
    n_checks++;
    if (cfg_err !== 1'b1) begin
      n_fail++;
      $display("FAIL drop cfg_err: got %b, expected 1", cfg_err);
    end
    drive_vs(4, 36);
    compare_cfg("after_drop", ACC_W);
    drive_lines(16, 64, 0, 1'b1, 1'b1);
    compare_frame("after_drop");
  endtask

  task automatic test_reset_mid_divide();
    model_cfg(64, 16, 32, 8, 1'b1);
    vid_in.vs = 1'b1;
    step(4);
    vid_in.vs = 1'b0;
    step(6);
    n_checks++;
    if (cfg_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL middiv busy before reset: got %b, expected 1", cfg_busy);
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    n_checks++;
    if (cfg_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL middiv busy after reset: got %b, expected 0", cfg_busy);
    end
    model_cfg(64, 16, 32, 8, 1'b0);
    compare_cfg("middiv_reset", -1);
    step(4);
    drive_lines(6, 20, 0, 1'b1, 1'b1);
    compare_frame("middiv_passthrough");
    model_cfg(64, 16, 32, 8, 1'b1);
    drive_vs(4, 36);
    compare_cfg("middiv_recompute", ACC_W);
    drive_lines(16, 64, 0, 1'b1, 1'b1);
    compare_frame("middiv_recompute");
  endtask

  task automatic test_back_to_back();
    model_cfg(40, 8, 20, 4, 1'b1);
    vid_in.vs = 1'b1;
    step(4);
    vid_in.vs = 1'b0;
    step(10);
    model_cfg(60, 9, 45, 3, 1'b1);
    drive_vs(4, 36);
    compare_cfg("rerise", -1);
    drive_lines(9, 60, 0, 1'b1, 1'b1);
    compare_frame("rerise");
  endtask

  task automatic test_short_lines();
    model_cfg(50, 8, 20, 5, 1'b1);
    drive_vs(4, 36);
    compare_cfg("short", ACC_W);
    drive_lines(8, 50, 17, 1'b1, 1'b0);
    compare_frame("short");
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int xi, yi, xo, yo, sl;
      bit en;
      xi = $urandom_range(8, 80);
      yi = $urandom_range(2, 10);
      xo = $urandom_range(1, xi);
      yo = $urandom_range(1, yi);
      en = ($urandom_range(0, 3) != 0);
      sl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, xi - 1) : 0;
      model_cfg(xi, yi, xo, yo, en);
      drive_vs(4, 36);
      compare_cfg($sformatf("rand%0d", f), exp_busy);
      drive_lines(yi, xi, sl, 1'b1, 1'b0);
      compare_frame($sformatf("rand%0d", f));
    end
  endtask

  initial begin
    vid_in.vs   = 1'b0;
    vid_in.hs   = 1'b0;
    vid_in.de   = 1'b0;
    vid_in.data = '0;
    test_reset();
    test_downscale_2to1();
    test_non_integer();
    test_invalid();
    test_passthrough();
    test_frame_drop();
    test_reset_mid_divide();
    test_back_to_back();
    test_short_lines();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
